// File: rtl/riscv_multi_cycle.sv
// Multi-cycle RV32I subset core: FSM controller plus datapath sharing one unified memory port.
module riscv_multi_cycle #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Adr,
    output logic            MemWrite,
    output logic [XLEN-1:0] WriteData,
    input  logic [XLEN-1:0] ReadData
);

    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] pc_q, instr_q, old_pc_q, alu_out_q, data_q, a_q, b_q;
    logic [XLEN-1:0] rf [2**REG_AW];

    // Instruction field decode from the latched instruction
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_j;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    // Register file reads; x0 is hardwired to zero
    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == '0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == '0) ? '0 : rf[rs2];

    // ALU shared by EXECR and EXECI; unsupported funct3 yields zero
    logic [XLEN-1:0] alu_b, alu_res;
    always_comb begin
        alu_b   = (state_q == EXECR) ? b_q : imm_i;
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = (state_q == EXECR && instr_q[30]) ? (a_q - alu_b) : (a_q + alu_b);
            3'b010:  alu_res = XLEN'($signed(a_q) < $signed(alu_b));
            3'b110:  alu_res = a_q | alu_b;
            3'b111:  alu_res = a_q & alu_b;
            default: alu_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic and combinational control (address mux, write strobes)
    logic            rf_we;
    logic [XLEN-1:0] rf_wd;
    always_comb begin
        state_d  = state_q;
        Adr      = pc_q;
        MemWrite = 1'b0;
        rf_we    = 1'b0;
        rf_wd    = alu_out_q;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_IALU:           state_d = EXECI;
                    OP_BEQ:            state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                Adr     = alu_out_q;
                state_d = MEMWB;
            end
            MEMWB: begin
                rf_we   = 1'b1;
                rf_wd   = data_q;
                state_d = FETCH;
            end
            MEMWRITE: begin
                Adr      = alu_out_q;
                MemWrite = 1'b1;
                state_d  = FETCH;
            end
            EXECR, EXECI: state_d = ALUWB;
            ALUWB: begin
                rf_we   = 1'b1;
                state_d = FETCH;
            end
            BEQ:      state_d = FETCH;
            JAL: begin
                rf_we   = 1'b1;
                rf_wd   = old_pc_q + XLEN'(4);
                state_d = FETCH;
            end
            default:  state_d = FETCH;
        endcase
        if (reset) rf_we = 1'b0;
    end

    // Datapath registers, updated according to the current FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            old_pc_q  <= '0;
            alu_out_q <= '0;
            data_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    instr_q  <= ReadData;
                    old_pc_q <= pc_q;
                    pc_q     <= pc_q + XLEN'(4);
                end
                DECODE: begin
                    a_q       <= rs1_val;
                    b_q       <= rs2_val;
                    alu_out_q <= old_pc_q + imm_b;
                end
                MEMADR:       alu_out_q <= a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
                MEMREAD:      data_q    <= ReadData;
                EXECR, EXECI: alu_out_q <= alu_res;
                BEQ:          if (a_q == b_q) pc_q <= alu_out_q;
                JAL:          pc_q <= old_pc_q + imm_j;
                default: ;
            endcase
        end
    end

    // Register file write port; x0 writes are dropped
    always_ff @(posedge clk) begin
        if (rf_we && rd != '0) rf[rd] <= rf_wd;
    end

    assign PC        = pc_q;
    assign WriteData = b_q;

endmodule

// File: tb/tb_riscv_multi_cycle.sv
// Directed self-checking bench for riscv_multi_cycle with a small unified memory model.
module tb_riscv_multi_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC, Adr, WriteData, ReadData;
    logic        MemWrite;
    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    riscv_multi_cycle dut (
        .clk       (clk),
        .reset     (reset),
        .PC        (PC),
        .Adr       (Adr),
        .MemWrite  (MemWrite),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    // Unified memory: combinational read, word write on the rising edge
    assign ReadData = mem[Adr[7:2]];
    always @(posedge clk) begin
        if (MemWrite) mem[Adr[7:2]] <= WriteData;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h0); end
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite: got %b expected 0", MemWrite); end
        reset = 1'b0;
        checks++; if (Adr !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected %h", Adr, 32'h0); end
        tick();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL first_fetch_pc: got %h expected %h", PC, 32'h4); end
        repeat (3) tick();
        checks++; if (dut.rf[1] !== 32'd5) begin errors++; $display("FAIL addi_x1: got %h expected %h", dut.rf[1], 32'd5); end
        checks++; if (Adr !== 32'h4) begin errors++; $display("FAIL next_fetch_adr: got %h expected %h", Adr, 32'h4); end
    endtask

    task automatic test_alu;
        int          rd_idx  [4] = '{2, 3, 4, 5};
        logic [31:0] exp_val [4] = '{32'hFFFF_FFFD, 32'd2, 32'd8, 32'd1};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (PC !== 32'(4 + 4 * i)) begin errors++; $display("FAIL alu_start_pc[%0d]: got %h expected %h", i, PC, 32'(4 + 4 * i)); end
            repeat (4) tick();
            checks++;
            if (dut.rf[rd_idx[i]] !== exp_val[i]) begin
                errors++; $display("FAIL alu_result_x%0d: got %h expected %h", rd_idx[i], dut.rf[rd_idx[i]], exp_val[i]);
            end
        end
    endtask

    task automatic test_store_load;
        int          wr_cycles = 0;
        logic [31:0] wr_adr = '0;
        logic [31:0] wr_data = '0;
        checks++; if (PC !== 32'h14) begin errors++; $display("FAIL sw_start_pc: got %h expected %h", PC, 32'h14); end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (MemWrite === 1'b1) begin
                wr_cycles++;
                wr_adr  = Adr;
                wr_data = WriteData;
            end
        end
        checks++; if (wr_cycles != 1) begin errors++; $display("FAIL sw_strobe_cycles: got %0d expected 1", wr_cycles); end
        checks++; if (wr_adr !== 32'h8) begin errors++; $display("FAIL sw_adr: got %h expected %h", wr_adr, 32'h8); end
        checks++; if (wr_data !== 32'd5) begin errors++; $display("FAIL sw_data: got %h expected %h", wr_data, 32'd5); end
        checks++; if (mem[2] !== 32'd5) begin errors++; $display("FAIL sw_mem: got %h expected %h", mem[2], 32'd5); end
        checks++; if (PC !== 32'h18) begin errors++; $display("FAIL lw_start_pc: got %h expected %h", PC, 32'h18); end
        repeat (3) tick();
        checks++; if (Adr !== 32'h8) begin errors++; $display("FAIL lw_memread_adr: got %h expected %h", Adr, 32'h8); end
        repeat (2) tick();
        checks++; if (dut.rf[6] !== 32'd5) begin errors++; $display("FAIL lw_x6: got %h expected %h", dut.rf[6], 32'd5); end
        checks++; if (PC !== 32'h1C) begin errors++; $display("FAIL lw_end_pc: got %h expected %h", PC, 32'h1C); end
    endtask

    task automatic test_illegal;
        repeat (2) tick();
        checks++; if (PC !== 32'h20) begin errors++; $display("FAIL illegal_pc: got %h expected %h", PC, 32'h20); end
        checks++; if (dut.rf[6] !== 32'd5) begin errors++; $display("FAIL illegal_no_write: got %h expected %h", dut.rf[6], 32'd5); end
    endtask

    task automatic test_branch;
        repeat (3) tick();
        checks++; if (PC !== 32'h28) begin errors++; $display("FAIL beq_taken_pc: got %h expected %h", PC, 32'h28); end
        repeat (3) tick();
        checks++; if (PC !== 32'h2C) begin errors++; $display("FAIL beq_not_taken_pc: got %h expected %h", PC, 32'h2C); end
    endtask

    task automatic test_jal;
        repeat (3) tick();
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL jal_fwd_pc: got %h expected %h", PC, 32'h40); end
        repeat (3) tick();
        checks++; if (PC !== 32'h30) begin errors++; $display("FAIL jal_back_pc: got %h expected %h", PC, 32'h30); end
        checks++; if (dut.rf[7] !== 32'h44) begin errors++; $display("FAIL jal_link_x7: got %h expected %h", dut.rf[7], 32'h44); end
        repeat (4) tick();
        checks++; if (PC !== 32'h34) begin errors++; $display("FAIL addi_x0_pc: got %h expected %h", PC, 32'h34); end
        repeat (4) tick();
        checks++; if (mem[3] !== 32'h0) begin errors++; $display("FAIL x0_reads_zero: got %h expected %h", mem[3], 32'h0); end
        checks++; if (PC !== 32'h38) begin errors++; $display("FAIL sw_x0_end_pc: got %h expected %h", PC, 32'h38); end
    endtask

    task automatic test_reset_mid;
        repeat (3) tick();
        checks++; if (Adr !== 32'h8) begin errors++; $display("FAIL mid_memread_adr: got %h expected %h", Adr, 32'h8); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL mid_reset_pc: got %h expected %h", PC, 32'h0); end
        checks++; if (Adr !== 32'h0) begin errors++; $display("FAIL mid_reset_adr: got %h expected %h", Adr, 32'h0); end
        tick();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL mid_refetch_pc: got %h expected %h", PC, 32'h4); end
        tick();
        checks++; if (dut.rf[5] !== 32'd1) begin errors++; $display("FAIL mid_rd_unchanged: got %h expected %h", dut.rf[5], 32'd1); end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0050_0093; // addi x1,x0,5
        mem[1]  = 32'hFFD0_0113; // addi x2,x0,-3
        mem[2]  = 32'h0020_81B3; // add  x3,x1,x2
        mem[3]  = 32'h4020_8233; // sub  x4,x1,x2
        mem[4]  = 32'h0011_22B3; // slt  x5,x2,x1
        mem[5]  = 32'h0010_2423; // sw   x1,8(x0)
        mem[6]  = 32'h0080_2303; // lw   x6,8(x0)
        mem[7]  = 32'h0000_007F; // unknown opcode
        mem[8]  = 32'h0010_8463; // beq  x1,x1,+8
        mem[9]  = 32'h0010_0413; // addi x8,x0,1 (skipped)
        mem[10] = 32'h0020_8463; // beq  x1,x2,+8
        mem[11] = 32'h0140_006F; // jal  x0,+20
        mem[12] = 32'h0070_0013; // addi x0,x0,7
        mem[13] = 32'h0000_2623; // sw   x0,12(x0)
        mem[14] = 32'h0080_2283; // lw   x5,8(x0)
        mem[16] = 32'hFF1F_F3EF; // jal  x7,-16
        test_reset();
        test_alu();
        test_store_load();
        test_illegal();
        test_branch();
        test_jal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
